// File: rtl/ram_access_controller_if.sv
// Request/response bundle between the control unit and the RAM access stage.
// The master side drives MOV/RW/SSE/SE/Address/DataIn and receives DataOut/MOC/AErr.
interface ram_access_controller_if;
  logic        MOV;
  logic        RW;
  logic [1:0]  SSE;
  logic        SE;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        AErr;

  modport master (
    output MOV, RW, SSE, SE, Address, DataIn,
    input  DataOut, MOC, AErr
  );

  modport slave (
    input  MOV, RW, SSE, SE, Address, DataIn,
    output DataOut, MOC, AErr
  );
endinterface

// File: rtl/ram_access_controller.sv
// Multi-cycle big-endian byte-addressable RAM access stage with a level MOC handshake.
// MOC rises WAIT_CYCLES+2 edges after MOV is sampled and holds until MOV drops.
module ram_access_controller #(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  ram_access_controller_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_rw;
  logic [1:0]  r_sse;
  logic        r_se;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic [31:0] r_dout;
  logic        r_moc;
  logic        r_aerr;

  logic [7:0]  r_mem [DEPTH];

  logic          w_access;
  logic          w_err;
  logic          w_wr_en;
  logic [AW-1:0] w_a0;
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a3;
  logic [7:0]    w_b0;
  logic [7:0]    w_b1;
  logic [7:0]    w_b2;
  logic [7:0]    w_b3;
  logic [31:0]   w_rdata;

  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_wr_en  = w_access && !r_rw && !w_err;

  assign w_a0 = r_addr[AW-1:0];
  assign w_a1 = w_a0 + AW'(1);
  assign w_a2 = w_a0 + AW'(2);
  assign w_a3 = w_a0 + AW'(3);

  assign w_b0 = r_mem[w_a0];
  assign w_b1 = r_mem[w_a1];
  assign w_b2 = r_mem[w_a2];
  assign w_b3 = r_mem[w_a3];

  // Aligned accesses never straddle the top since DEPTH is a multiple of 4,
  // so checking the base address against DEPTH covers every byte.
  always_comb begin
    w_err = 1'b0;
    case (r_sse)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = r_addr[0];
      2'b10:   w_err = (r_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
    if (r_addr[31:AW] != '0) begin
      w_err = 1'b1;
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    case (r_sse)
      2'b00:   w_rdata = {{24{r_se & w_b0[7]}}, w_b0};
      2'b01:   w_rdata = {{16{r_se & w_b0[7]}}, w_b0, w_b1};
      default: w_rdata = {w_b0, w_b1, w_b2, w_b3};
    endcase
  end

  // No reset on the array: contents survive reset, and an abort is safe
  // because reset forces the state away from BUSY before any write edge.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      case (r_sse)
        2'b00: begin
          r_mem[w_a0] <= r_din[7:0];
        end
        2'b01: begin
          r_mem[w_a0] <= r_din[15:8];
          r_mem[w_a1] <= r_din[7:0];
        end
        default: begin
          r_mem[w_a0] <= r_din[31:24];
          r_mem[w_a1] <= r_din[23:16];
          r_mem[w_a2] <= r_din[15:8];
          r_mem[w_a3] <= r_din[7:0];
        end
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.MOV) w_next = BUSY;
      BUSY:    if (r_cnt == 4'd0) w_next = DONE;
      DONE:    if (r_moc && !bus.MOV) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= 1'b0;
      r_sse   <= 2'b00;
      r_se    <= 1'b0;
      r_addr  <= 32'h0;
      r_din   <= 32'h0;
      r_dout  <= 32'h0;
      r_moc   <= 1'b0;
      r_aerr  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.MOV) begin
            r_rw   <= bus.RW;
            r_sse  <= bus.SSE;
            r_se   <= bus.SE;
            r_addr <= bus.Address;
            r_din  <= bus.DataIn;
            r_cnt  <= 4'(WAIT_CYCLES);
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_aerr <= w_err;
            if (r_rw && !w_err) begin
              r_dout <= w_rdata;
            end
          end
        end
        DONE: begin
          // First DONE cycle raises MOC; afterwards MOC tracks MOV release.
          if (!r_moc) begin
            r_moc <= 1'b1;
          end else if (!bus.MOV) begin
            r_moc  <= 1'b0;
            r_aerr <= 1'b0;
          end
        end
        default: begin
          r_moc <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DataOut = r_dout;
  assign bus.MOC     = r_moc;
  assign bus.AErr    = r_aerr;
endmodule

// File: tb/tb_ram_access_controller.sv
// Directed bench for ram_access_controller: a byte-array reference model feeds a
// scoreboard of expected read data / error flags that is popped whenever MOC rises.
module tb_ram_access_controller;
  localparam int DEPTH = 512;
  localparam int WAIT_CYCLES = 2;

  typedef struct packed {
    logic [31:0] dout;
    logic        aerr;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  logic [7:0]  m_mem [DEPTH];
  logic [31:0] m_dout;
  exp_t        sbq [$];

  ram_access_controller_if bus ();

  ram_access_controller #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic rw, input logic [1:0] sse, input logic se,
                                 input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic err;
    int   i;
    err = (sse == 2'b11) || (sse == 2'b01 && a[0]) ||
          (sse == 2'b10 && a[1:0] != 2'b00) || (a >= DEPTH);
    i = int'(a[8:0]);
    if (!err) begin
      if (!rw) begin
        if (sse == 2'b00) begin
          m_mem[i] = d[7:0];
        end else if (sse == 2'b01) begin
          m_mem[i]   = d[15:8];
          m_mem[i+1] = d[7:0];
        end else begin
          for (int k = 0; k < 4; k++) m_mem[i+k] = d[31-8*k -: 8];
        end
      end else begin
        if (sse == 2'b00)
          m_dout = se ? {{24{m_mem[i][7]}}, m_mem[i]} : {24'h0, m_mem[i]};
        else if (sse == 2'b01)
          m_dout = se ? {{16{m_mem[i][7]}}, m_mem[i], m_mem[i+1]} : {16'h0, m_mem[i], m_mem[i+1]};
        else
          m_dout = {m_mem[i], m_mem[i+1], m_mem[i+2], m_mem[i+3]};
      end
    end
    e.dout = m_dout;
    e.aerr = err;
    return e;
  endfunction

  // mode 0: normal; 1: perturb Address/DataIn during BUSY; 2: drop MOV during BUSY
  task automatic op(input string tag, input logic rw, input logic [1:0] sse, input logic se,
                    input logic [31:0] a, input logic [31:0] d, input int hold, input int mode);
    exp_t e;
    int   edges;
    sbq.push_back(model(rw, sse, se, a, d));
    @(negedge clk);
    bus.MOV = 1'b1; bus.RW = rw; bus.SSE = sse; bus.SE = se;
    bus.Address = a; bus.DataIn = d;
    @(posedge clk);
    #1;
    if (mode == 1) begin
      bus.Address = a ^ 32'h40;
      bus.DataIn  = ~d;
    end
    if (mode == 2) bus.MOV = 1'b0;
    edges = 0;
    do begin
      @(posedge clk); #1; edges++;
    end while (bus.MOC !== 1'b1 && edges < 50);
    chk({tag, " latency"}, 32'(edges), 32'(WAIT_CYCLES + 2));
    e = sbq.pop_front();
    chk({tag, " DataOut"}, bus.DataOut, e.dout);
    chk({tag, " AErr"}, {31'h0, bus.AErr}, {31'h0, e.aerr});
    if (mode == 2) begin
      @(posedge clk); #1;
      chk({tag, " MOC pulse end"}, {31'h0, bus.MOC}, 32'h0);
    end else begin
      for (int h = 0; h < hold; h++) begin
        // a different request while in DONE must be ignored
        bus.RW = ~rw; bus.Address = a + 32'h4;
        @(posedge clk); #1;
        chk({tag, " MOC held"}, {31'h0, bus.MOC}, 32'h1);
        chk({tag, " AErr held"}, {31'h0, bus.AErr}, {31'h0, e.aerr});
      end
      @(negedge clk);
      bus.MOV = 1'b0;
      @(posedge clk); #1;
      chk({tag, " MOC release"}, {31'h0, bus.MOC}, 32'h0);
      chk({tag, " AErr release"}, {31'h0, bus.AErr}, 32'h0);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; m_dout = 32'h0;
    reset = 1'b0;
    bus.MOV = 1'b0; bus.RW = 1'b0; bus.SSE = 2'b00; bus.SE = 1'b0;
    bus.Address = 32'h0; bus.DataIn = 32'h0;
    #1;
    chk("reset MOC", {31'h0, bus.MOC}, 32'h0);
    chk("reset AErr", {31'h0, bus.AErr}, 32'h0);
    chk("reset DataOut", bus.DataOut, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    op("wr w4",  1'b0, 2'b10, 1'b0, 32'd4, 32'h11223344, 0, 0);
    op("wr w8",  1'b0, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, 0, 0);
    for (int b = 8; b < 12; b++) op("rd byte", 1'b1, 2'b00, 1'b0, 32'(b), 32'h0, 0, 0);
    op("rd w8",  1'b1, 2'b10, 1'b0, 32'd8, 32'h0, 0, 0);
    op("rd b10 se1", 1'b1, 2'b00, 1'b1, 32'd10, 32'h0, 0, 0);
    op("rd b10 se0", 1'b1, 2'b00, 1'b0, 32'd10, 32'h0, 0, 0);
    op("rd h8 se1",  1'b1, 2'b01, 1'b1, 32'd8, 32'h0, 0, 0);
    op("rd h10 se0", 1'b1, 2'b01, 1'b0, 32'd10, 32'h0, 0, 0);

    op("wr w6 misalign", 1'b0, 2'b10, 1'b0, 32'd6, 32'hA5A5A5A5, 0, 0);
    for (int b = 6; b < 10; b++) op("rd after err", 1'b1, 2'b00, 1'b0, 32'(b), 32'h0, 0, 0);
    op("rd h top",  1'b1, 2'b01, 1'b0, 32'(DEPTH - 1), 32'h0, 0, 0);
    op("rd sse11",  1'b1, 2'b11, 1'b0, 32'd8, 32'h0, 0, 0);
    op("rd w range", 1'b1, 2'b10, 1'b0, 32'(DEPTH), 32'h0, 0, 0);

    op("wr w16", 1'b0, 2'b10, 1'b0, 32'd16, 32'h00000000, 0, 0);
    op("wr h18", 1'b0, 2'b01, 1'b0, 32'd18, 32'h1234CAFE, 0, 0);
    op("wr b16", 1'b0, 2'b00, 1'b0, 32'd16, 32'h000000A5, 0, 0);
    op("rd w16", 1'b1, 2'b10, 1'b0, 32'd16, 32'h0, 0, 0);

    op("hold 5", 1'b1, 2'b10, 1'b0, 32'd8, 32'h0, 5, 0);
    op("drop busy", 1'b1, 2'b10, 1'b0, 32'd4, 32'h0, 0, 2);
    op("wr stable", 1'b0, 2'b10, 1'b0, 32'd12, 32'h0BADF00D, 0, 1);
    op("rd stable", 1'b1, 2'b10, 1'b0, 32'd12, 32'h0, 0, 0);

    chk("pre-reset DataOut", bus.DataOut, m_dout);
    @(negedge clk);
    bus.MOV = 1'b1; bus.RW = 1'b0; bus.SSE = 2'b10; bus.SE = 1'b0;
    bus.Address = 32'd8; bus.DataIn = 32'h55555555;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort MOC", {31'h0, bus.MOC}, 32'h0);
    chk("abort AErr", {31'h0, bus.AErr}, 32'h0);
    chk("abort DataOut", bus.DataOut, 32'h0);
    m_dout = 32'h0;
    @(negedge clk);
    bus.MOV = 1'b0;
    reset = 1'b1;
    op("rd after abort", 1'b1, 2'b10, 1'b0, 32'd8, 32'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
